fb_rast_write_port: RTL and testbench

FB_RAST_WRITE_PORT -- requirements
Module: fb_rast_write_port

---
 rtl/fb_rast_write_port.sv | 158 +++++++++++++++
 tb/tb_fb_rast_write_port.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_rast_write_port.sv
// Rasterizer-to-framebuffer write port: clears the back bank, accepts pixels
// through a one-entry output register, and swaps banks on the frame tick.
module fb_rast_write_port #(
    parameter int unsigned H_RES = 640,
    parameter int unsigned V_RES = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rast_pixel_rdy,
    input  logic [9:0]  rast_width,
    input  logic [8:0]  rast_height,
    input  logic [2:0]  rast_color_input,
    input  logic        rast_done,
    input  logic        next_frame_switch,
    input  logic [2:0]  bk_color,
    input  logic        mem_wr_ready,
    output logic        read_rast_pixel_rdy,
    output logic        mem_wr_en,
    output logic [19:0] mem_wr_addr,
    output logic [2:0]  mem_wr_data,
    output logic        disp_bank,
    output logic        frame_overrun,
    output logic        pixel_dropped
);

    localparam int unsigned NPIX     = H_RES * V_RES;
    localparam logic [18:0] LAST_IDX = 19'(NPIX - 1);

    typedef enum logic [1:0] {
        CLEAR,
        ACCEPT,
        WAIT_SWAP
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [18:0] r_clr_cnt, w_clr_cnt_nxt;
    logic        r_clr_last, w_clr_last_nxt;
    logic        r_disp_bank, w_disp_bank_nxt;
    logic        r_wr_en, w_wr_en_nxt;
    logic [19:0] r_wr_addr, w_wr_addr_nxt;
    logic [2:0]  r_wr_data, w_wr_data_nxt;
    logic        r_overrun, w_overrun_nxt;
    logic        r_dropped, w_dropped_nxt;

    logic        w_slot_free;
    logic        w_accept;
    logic        w_in_range;
    logic [18:0] w_index;

    // The output register can take a new entry when empty or retiring this cycle.
    assign w_slot_free         = !r_wr_en || mem_wr_ready;
    assign read_rast_pixel_rdy = (r_state == ACCEPT) && w_slot_free;
    assign w_accept            = rast_pixel_rdy && read_rast_pixel_rdy;
    assign w_in_range          = (32'(rast_width) < H_RES) && (32'(rast_height) < V_RES);
    assign w_index             = 19'(32'(rast_height) * H_RES + 32'(rast_width));

    always_comb begin
        w_state_nxt     = r_state;
        w_clr_cnt_nxt   = r_clr_cnt;
        w_clr_last_nxt  = r_clr_last;
        w_disp_bank_nxt = r_disp_bank;
        w_wr_en_nxt     = r_wr_en;
        w_wr_addr_nxt   = r_wr_addr;
        w_wr_data_nxt   = r_wr_data;
        w_overrun_nxt   = 1'b0;
        w_dropped_nxt   = 1'b0;

        if (w_slot_free) begin
            w_wr_en_nxt = 1'b0;
        end

        case (r_state)
            CLEAR: begin
                if (next_frame_switch) begin
                    w_overrun_nxt = 1'b1;
                end
                if (w_slot_free) begin
                    if (!r_clr_last) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = {~r_disp_bank, r_clr_cnt};
                        w_wr_data_nxt = bk_color;
                        // Counter parks on the last index; r_clr_last marks it issued.
                        if (r_clr_cnt == LAST_IDX) begin
                            w_clr_last_nxt = 1'b1;
                        end else begin
                            w_clr_cnt_nxt = r_clr_cnt + 19'd1;
                        end
                    end else begin
                        w_state_nxt = ACCEPT;
                    end
                end
            end

            ACCEPT: begin
                if (next_frame_switch) begin
                    w_overrun_nxt = 1'b1;
                end
                if (w_accept) begin
                    if (w_in_range) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = {~r_disp_bank, w_index};
                        w_wr_data_nxt = rast_color_input;
                    end else begin
                        w_dropped_nxt = 1'b1;
                    end
                end
                if (rast_done) begin
                    w_state_nxt = WAIT_SWAP;
                end
            end

            WAIT_SWAP: begin
                if (next_frame_switch && !r_wr_en) begin
                    w_disp_bank_nxt = ~r_disp_bank;
                    w_clr_cnt_nxt   = '0;
                    w_clr_last_nxt  = 1'b0;
                    w_state_nxt     = CLEAR;
                end
            end

            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= CLEAR;
            r_clr_cnt   <= '0;
            r_clr_last  <= 1'b0;
            r_disp_bank <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_overrun   <= 1'b0;
            r_dropped   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_cnt   <= w_clr_cnt_nxt;
            r_clr_last  <= w_clr_last_nxt;
            r_disp_bank <= w_disp_bank_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_overrun   <= w_overrun_nxt;
            r_dropped   <= w_dropped_nxt;
        end
    end

    assign mem_wr_en     = r_wr_en;
    assign mem_wr_addr   = r_wr_addr;
    assign mem_wr_data   = r_wr_data;
    assign disp_bank     = r_disp_bank;
    assign frame_overrun = r_overrun;
    assign pixel_dropped = r_dropped;

endmodule

// File: tb/tb_fb_rast_write_port.sv
// Directed bench for fb_rast_write_port on a reduced 20x10 frame so whole
// clears fit in a short run; pixel vectors are table-driven.
module tb_fb_rast_write_port;

    localparam int unsigned H = 20;
    localparam int unsigned V = 10;
    localparam int NPIX = H * V;

    logic        clk;
    logic        rst;
    logic        rast_pixel_rdy;
    logic [9:0]  rast_width;
    logic [8:0]  rast_height;
    logic [2:0]  rast_color_input;
    logic        rast_done;
    logic        next_frame_switch;
    logic [2:0]  bk_color;
    logic        mem_wr_ready;
    logic        read_rast_pixel_rdy;
    logic        mem_wr_en;
    logic [19:0] mem_wr_addr;
    logic [2:0]  mem_wr_data;
    logic        disp_bank;
    logic        frame_overrun;
    logic        pixel_dropped;

    fb_rast_write_port #(.H_RES(H), .V_RES(V)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rast_pixel_rdy      (rast_pixel_rdy),
        .rast_width          (rast_width),
        .rast_height         (rast_height),
        .rast_color_input    (rast_color_input),
        .rast_done           (rast_done),
        .next_frame_switch   (next_frame_switch),
        .bk_color            (bk_color),
        .mem_wr_ready        (mem_wr_ready),
        .read_rast_pixel_rdy (read_rast_pixel_rdy),
        .mem_wr_en           (mem_wr_en),
        .mem_wr_addr         (mem_wr_addr),
        .mem_wr_data         (mem_wr_data),
        .disp_bank           (disp_bank),
        .frame_overrun       (frame_overrun),
        .pixel_dropped       (pixel_dropped)
    );

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [2:0]  color;
        logic        expWr;
        logic [19:0] expAddr;
        logic        expDrop;
    } vec_t;

    vec_t vecs[7];
    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] x, input logic [8:0] y, input logic [2:0] c);
        rast_pixel_rdy   = 1'b1;
        rast_width       = x;
        rast_height      = y;
        rast_color_input = c;
    endtask

    task automatic pulseTick();
        next_frame_switch = 1'b1;
        @(negedge clk);
        next_frame_switch = 1'b0;
    endtask

    // Follows a whole clear pass from the current negedge, checking every accepted write.
    task automatic waitClear(input logic bank, input logic [2:0] color, input bit throttle);
        int idx = 0;
        int cyc = 0;
        while (read_rast_pixel_rdy !== 1'b1 && cyc < 3 * NPIX + 50) begin
            if (throttle) mem_wr_ready = (cyc % 3 != 2);
            if (mem_wr_en === 1'b1 && mem_wr_ready === 1'b1) begin
                checkOutput("clearAddr", 32'(mem_wr_addr), 32'({bank, 19'(idx)}));
                checkOutput("clearData", 32'(mem_wr_data), 32'(color));
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        mem_wr_ready = 1'b1;
        checkOutput("clearCount", idx, NPIX);
        checkOutput("clearDoneRdy", 32'(read_rast_pixel_rdy), 32'd1);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rstWrEn", 32'(mem_wr_en), 32'd0);
        checkOutput("rstAddr", 32'(mem_wr_addr), 32'd0);
        checkOutput("rstData", 32'(mem_wr_data), 32'd0);
        checkOutput("rstRdy", 32'(read_rast_pixel_rdy), 32'd0);
        checkOutput("rstBank", 32'(disp_bank), 32'd0);
        checkOutput("rstOverrun", 32'(frame_overrun), 32'd0);
        checkOutput("rstDropped", 32'(pixel_dropped), 32'd0);
    endtask

    initial begin
        rst = 1'b0; rast_pixel_rdy = 1'b0; rast_width = '0; rast_height = '0;
        rast_color_input = '0; rast_done = 1'b0; next_frame_switch = 1'b0;
        bk_color = 3'b001; mem_wr_ready = 1'b1;

        vecs[0] = '{10'd5,    9'd3,   3'd5, 1'b1, 20'h80041, 1'b0};
        vecs[1] = '{10'd19,   9'd9,   3'd7, 1'b1, 20'h800C7, 1'b0};
        vecs[2] = '{10'd0,    9'd0,   3'd2, 1'b1, 20'h80000, 1'b0};
        vecs[3] = '{10'd7,    9'd6,   3'd3, 1'b1, 20'h8007F, 1'b0};
        vecs[4] = '{10'd20,   9'd3,   3'd1, 1'b0, 20'h00000, 1'b1};
        vecs[5] = '{10'd4,    9'd10,  3'd6, 1'b0, 20'h00000, 1'b1};
        vecs[6] = '{10'd1023, 9'd511, 3'd4, 1'b0, 20'h00000, 1'b1};

        repeat (2) @(negedge clk);
        checkResetOutputs();

        // First clear after reset targets bank 1 starting on the first edge.
        rst = 1'b1;
        @(negedge clk);
        checkOutput("firstWrEn", 32'(mem_wr_en), 32'd1);
        checkOutput("firstWrAddr", 32'(mem_wr_addr), 32'h80000);
        waitClear(1'b1, 3'b001, 1'b0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].x, vecs[i].y, vecs[i].color);
            #1;
            checkOutput($sformatf("v%0d_rdy", i), 32'(read_rast_pixel_rdy), 32'd1);
            @(negedge clk);
            rast_pixel_rdy = 1'b0;
            checkOutput($sformatf("v%0d_wrEn", i), 32'(mem_wr_en), 32'(vecs[i].expWr));
            if (vecs[i].expWr) begin
                checkOutput($sformatf("v%0d_addr", i), 32'(mem_wr_addr), 32'(vecs[i].expAddr));
                checkOutput($sformatf("v%0d_data", i), 32'(mem_wr_data), 32'(vecs[i].color));
            end
            checkOutput($sformatf("v%0d_drop", i), 32'(pixel_dropped), 32'(vecs[i].expDrop));
            @(negedge clk);
            checkOutput($sformatf("v%0d_idleEn", i), 32'(mem_wr_en), 32'd0);
            checkOutput($sformatf("v%0d_dropEnd", i), 32'(pixel_dropped), 32'd0);
        end

        // Backpressure: pixel A held four cycles, pixel B waits and is not lost.
        mem_wr_ready = 1'b0;
        applyStimulus(10'd2, 9'd1, 3'd4);
        @(negedge clk);
        applyStimulus(10'd3, 9'd2, 3'd6);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checkOutput("holdEn", 32'(mem_wr_en), 32'd1);
            checkOutput("holdAddr", 32'(mem_wr_addr), 32'h80016);
            checkOutput("holdData", 32'(mem_wr_data), 32'd4);
            checkOutput("holdRdy", 32'(read_rast_pixel_rdy), 32'd0);
        end
        mem_wr_ready = 1'b1;
        #1;
        checkOutput("releaseRdy", 32'(read_rast_pixel_rdy), 32'd1);
        @(negedge clk);
        rast_pixel_rdy = 1'b0;
        checkOutput("pixelBEn", 32'(mem_wr_en), 32'd1);
        checkOutput("pixelBAddr", 32'(mem_wr_addr), 32'h8002B);
        checkOutput("pixelBData", 32'(mem_wr_data), 32'd6);
        @(negedge clk);
        checkOutput("pixelBRetired", 32'(mem_wr_en), 32'd0);

        // Tick while accepting is an overrun and changes nothing else.
        pulseTick();
        checkOutput("acceptOverrun", 32'(frame_overrun), 32'd1);
        checkOutput("acceptOverrunBank", 32'(disp_bank), 32'd0);
        checkOutput("acceptStillRdy", 32'(read_rast_pixel_rdy), 32'd1);
        @(negedge clk);
        checkOutput("acceptOverrunEnd", 32'(frame_overrun), 32'd0);

        // Pixel accepted with rast_done is written; tick ignored while it is pending.
        mem_wr_ready = 1'b0;
        applyStimulus(10'd1, 9'd1, 3'd5);
        rast_done = 1'b1;
        @(negedge clk);
        rast_pixel_rdy = 1'b0;
        rast_done = 1'b0;
        checkOutput("donePixEn", 32'(mem_wr_en), 32'd1);
        checkOutput("donePixAddr", 32'(mem_wr_addr), 32'h80015);
        checkOutput("donePixData", 32'(mem_wr_data), 32'd5);
        checkOutput("waitRdy", 32'(read_rast_pixel_rdy), 32'd0);
        pulseTick();
        checkOutput("pendingNoSwap", 32'(disp_bank), 32'd0);
        checkOutput("pendingNoOverrun", 32'(frame_overrun), 32'd0);
        checkOutput("pendingHeld", 32'(mem_wr_en), 32'd1);
        mem_wr_ready = 1'b1;
        @(negedge clk);
        checkOutput("pendingRetired", 32'(mem_wr_en), 32'd0);
        bk_color = 3'b110;
        pulseTick();
        checkOutput("swapBank1", 32'(disp_bank), 32'd1);
        checkOutput("swapNoOverrun", 32'(frame_overrun), 32'd0);
        waitClear(1'b0, 3'b110, 1'b1);

        // Tick together with rast_done: overrun, then swap on the following tick.
        next_frame_switch = 1'b1;
        rast_done = 1'b1;
        @(negedge clk);
        next_frame_switch = 1'b0;
        rast_done = 1'b0;
        checkOutput("bothOverrun", 32'(frame_overrun), 32'd1);
        checkOutput("bothBank", 32'(disp_bank), 32'd1);
        checkOutput("bothRdy", 32'(read_rast_pixel_rdy), 32'd0);
        @(negedge clk);
        checkOutput("bothOverrunEnd", 32'(frame_overrun), 32'd0);
        mem_wr_ready = 1'b0;
        bk_color = 3'b011;
        pulseTick();
        checkOutput("swapBank0", 32'(disp_bank), 32'd0);
        @(negedge clk);
        checkOutput("clr1FirstEn", 32'(mem_wr_en), 32'd1);
        checkOutput("clr1FirstAddr", 32'(mem_wr_addr), 32'h80000);
        pulseTick();
        checkOutput("clearOverrun", 32'(frame_overrun), 32'd1);
        checkOutput("clearOverrunBank", 32'(disp_bank), 32'd0);
        checkOutput("clearHeldAddr", 32'(mem_wr_addr), 32'h80000);
        mem_wr_ready = 1'b1;
        waitClear(1'b1, 3'b011, 1'b0);

        // Reset in the middle of a bank-0 clear restarts everything at bank 1.
        rast_done = 1'b1;
        @(negedge clk);
        rast_done = 1'b0;
        pulseTick();
        checkOutput("swapBank1Again", 32'(disp_bank), 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("midClearEn", 32'(mem_wr_en), 32'd1);
        checkOutput("midClearBank0", 32'(mem_wr_addr[19]), 32'd0);
        rst = 1'b0;
        #1;
        checkResetOutputs();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("restartEn", 32'(mem_wr_en), 32'd1);
        checkOutput("restartAddr", 32'(mem_wr_addr), 32'h80000);
        waitClear(1'b1, 3'b011, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
